// File: rtl/fixed_point_divider.sv
// Sequential signed fixed-point divider.
// Computes quotient = (dividend << FRAC) / divisor, truncated toward zero.
// Saturates to the signed N-bit range. The remainder takes the sign of the dividend.
// Restoring shift-subtract, one quotient bit per clock.
//
// Handshake:
//   - start is sampled only in IDLE.
//   - busy is high while the division is in DIV or FIX.
//   - done pulses for one cycle in DONE.
//   - Result and flags are valid from the done cycle onward.
//   - They hold until the next FIX.
module fixed_point_divider #(
    parameter int N    = 24,
    parameter int FRAC = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         Z,
    output logic         Neg,
    output logic         V,
    output logic         dz,
    output logic [1:0]   o_dbg_state
);

    localparam int NW = N + FRAC;
    localparam int CW = $clog2(NW + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DIV  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [N-1:0]  Q_MAX       = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0]  Q_MIN       = {1'b1, {(N-1){1'b0}}};
    localparam logic [NW-1:0] MAG_MAX_POS = {{(FRAC+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic [NW-1:0] MAG_MIN_NEG = {{FRAC{1'b0}}, 1'b1, {(N-1){1'b0}}};

    logic [1:0]    r_state;
    logic          r_sign_a;
    logic          r_sign_b;
    logic [NW-1:0] r_num;      // numerator bits shift out, quotient bits shift in
    logic [N-1:0]  r_dmag;
    logic [N-1:0]  r_prem;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_quot;
    logic [N-1:0]  r_rem;
    logic          r_z;
    logic          r_neg;
    logic          r_v;
    logic          r_dz;

    // Operand magnitudes as N-bit unsigned values.
    // -2^(N-1) negates to itself, which read unsigned is exactly 2^(N-1).
    logic [N-1:0]  w_a_mag;
    logic [N-1:0]  w_b_mag;
    logic [N:0]    w_prem_sh;
    logic          w_ge;
    logic [N-1:0]  w_prem_nx;
    logic [N-1:0]  w_fix_q;
    logic [N-1:0]  w_fix_r;
    logic          w_fix_v;
    logic          w_neg_res;

    assign w_a_mag = dividend[N-1] ? (~dividend + N'(1)) : dividend;
    assign w_b_mag = divisor[N-1]  ? (~divisor  + N'(1)) : divisor;

    // One restoring step.
    // The partial remainder stays below |divisor| <= 2^(N-1).
    // So the N-bit difference cannot wrap.
    assign w_prem_sh = {r_prem, r_num[NW-1]};
    assign w_ge      = (w_prem_sh >= {1'b0, r_dmag});
    assign w_prem_nx = w_ge ? (w_prem_sh[N-1:0] - r_dmag) : w_prem_sh[N-1:0];

    assign w_neg_res = (r_sign_a ^ r_sign_b) && (r_num != '0);

    // Sign application and saturation of the finished magnitude.
    always_comb begin
        w_fix_q = r_num[N-1:0];
        w_fix_r = r_sign_a ? (~r_prem + N'(1)) : r_prem;
        w_fix_v = 1'b0;
        if (r_dmag == '0) begin
            w_fix_q = r_sign_a ? Q_MIN : Q_MAX;
            w_fix_r = '0;
            w_fix_v = 1'b1;
        end else if (w_neg_res) begin
            if (r_num > MAG_MIN_NEG) begin
                w_fix_q = Q_MIN;
                w_fix_v = 1'b1;
            end else begin
                w_fix_q = ~r_num[N-1:0] + N'(1);
            end
        end else if (r_num > MAG_MAX_POS) begin
            w_fix_q = Q_MAX;
            w_fix_v = 1'b1;
        end
    end

    // Control FSM, iteration datapath and registered results.
    // In DIV, the cycle that finds the counter at zero hands over to FIX.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_num    <= '0;
            r_dmag   <= '0;
            r_prem   <= '0;
            r_cnt    <= '0;
            r_quot   <= '0;
            r_rem    <= '0;
            r_z      <= 1'b1;
            r_neg    <= 1'b0;
            r_v      <= 1'b0;
            r_dz     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sign_a <= dividend[N-1];
                        r_sign_b <= divisor[N-1];
                        r_num    <= {w_a_mag, {FRAC{1'b0}}};
                        r_dmag   <= w_b_mag;
                        r_prem   <= '0;
                        r_cnt    <= CW'(NW);
                        r_state  <= S_DIV;
                    end
                end
                S_DIV: begin
                    if (r_cnt == '0) begin
                        r_state <= S_FIX;
                    end else begin
                        r_prem <= w_prem_nx;
                        r_num  <= {r_num[NW-2:0], w_ge};
                        r_cnt  <= r_cnt - CW'(1);
                    end
                end
                S_FIX: begin
                    r_quot  <= w_fix_q;
                    r_rem   <= w_fix_r;
                    r_z     <= (w_fix_q == '0);
                    r_neg   <= w_fix_q[N-1];
                    r_v     <= w_fix_v;
                    r_dz    <= (r_dmag == '0);
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = (r_state == S_DIV) || (r_state == S_FIX);
    assign done        = (r_state == S_DONE);
    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign Z           = r_z;
    assign Neg         = r_neg;
    assign V           = r_v;
    assign dz          = r_dz;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fixed_point_divider.sv
// Directed bench for fixed_point_divider, default Q16.8 in 24 bits.
module tb_fixed_point_divider;

    localparam int N   = 24;
    localparam int LAT = 34;

    logic          clk;
    logic          rst;
    logic          start;
    logic [N-1:0]  dividend;
    logic [N-1:0]  divisor;
    logic          busy;
    logic          done;
    logic [N-1:0]  quotient;
    logic [N-1:0]  remainder;
    logic          Z;
    logic          Neg;
    logic          V;
    logic          dz;
    logic [1:0]    o_dbg_state;

    int tests;
    int fails;

    fixed_point_divider #(.N(N), .FRAC(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder),
        .Z(Z), .Neg(Neg), .V(V), .dz(dz),
        .o_dbg_state(o_dbg_state)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: issue one division and wait for done.
    // Returns with the bench at the negedge of the done cycle.
    // lat counts rising edges after the start edge.
    task automatic run_div(input logic [N-1:0] a, input logic [N-1:0] b,
                           output int lat, output logic busy0);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = N'($urandom_range(0, 32'hFFFFFF));
        divisor  = N'($urandom_range(0, 32'hFFFFFF));
        busy0    = busy;
        lat      = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (done !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL timeout: done not seen, got %0d cycles, expected %0d", lat, LAT);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        dividend = 24'h000180;
        divisor  = 24'h000080;
        repeat (3) @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        tests++;
        if ({busy, done, quotient, remainder, Z, Neg, V, dz} !== {2'b00, 24'h0, 24'h0, 4'b1000}) begin
            fails++;
            $display("FAIL reset_values: got busy=%b done=%b q=%h r=%h ZNVd=%b%b%b%b, expected 0 0 000000 000000 1000",
                     busy, done, quotient, remainder, Z, Neg, V, dz);
        end
        @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL start_with_rst: got busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_basic();
        int lat;
        logic b0;
        run_div(24'h000180, 24'h000080, lat, b0);
        tests++;
        if (lat !== LAT) begin
            fails++;
            $display("FAIL basic_latency: got %0d, expected %0d", lat, LAT);
        end
        tests++;
        if (b0 !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_busy: got first=%b at_done=%b, expected 1 0", b0, busy);
        end
        tests++;
        if ({quotient, remainder, Z, Neg, V, dz} !== {24'h000300, 24'h0, 4'b0000}) begin
            fails++;
            $display("FAIL basic_1p5_div_0p5: got q=%h r=%h ZNVd=%b%b%b%b, expected 000300 000000 0000",
                     quotient, remainder, Z, Neg, V, dz);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL done_pulse_width: got done=%b one cycle later, expected 0", done);
        end
    endtask

    task automatic test_signs();
        int lat;
        logic b0;
        run_div(24'hFFFFA0, 24'h000040, lat, b0);
        tests++;
        if ({quotient, remainder, Z, Neg, V, dz} !== {24'hFFFE80, 24'h0, 4'b0100}) begin
            fails++;
            $display("FAIL neg_div_pos: got q=%h r=%h ZNVd=%b%b%b%b, expected fffe80 000000 0100",
                     quotient, remainder, Z, Neg, V, dz);
        end
        run_div(24'hFFFFA0, 24'hFFFFC0, lat, b0);
        tests++;
        if ({quotient, remainder, Z, Neg, V, dz} !== {24'h000180, 24'h0, 4'b0000}) begin
            fails++;
            $display("FAIL neg_div_neg: got q=%h r=%h ZNVd=%b%b%b%b, expected 000180 000000 0000",
                     quotient, remainder, Z, Neg, V, dz);
        end
    endtask

    task automatic test_trunc();
        int lat;
        logic b0;
        run_div(24'h000100, 24'h000300, lat, b0);
        tests++;
        if ({quotient, remainder, Z, Neg, V, dz} !== {24'h000055, 24'h000100, 4'b0000}) begin
            fails++;
            $display("FAIL trunc_1_div_3: got q=%h r=%h ZNVd=%b%b%b%b, expected 000055 000100 0000",
                     quotient, remainder, Z, Neg, V, dz);
        end
        run_div(24'hFFFF00, 24'h000300, lat, b0);
        tests++;
        if ({quotient, remainder, Z, Neg, V, dz} !== {24'hFFFFAB, 24'hFFFF00, 4'b0100}) begin
            fails++;
            $display("FAIL trunc_m1_div_3: got q=%h r=%h ZNVd=%b%b%b%b, expected ffffab ffff00 0100",
                     quotient, remainder, Z, Neg, V, dz);
        end
    endtask

    task automatic test_overflow();
        int lat;
        logic b0;
        run_div(24'h7FFFFF, 24'h000001, lat, b0);
        tests++;
        if ({quotient, remainder, Z, Neg, V, dz} !== {24'h7FFFFF, 24'h0, 4'b0010}) begin
            fails++;
            $display("FAIL overflow_pos: got q=%h r=%h ZNVd=%b%b%b%b, expected 7fffff 000000 0010",
                     quotient, remainder, Z, Neg, V, dz);
        end
        run_div(24'h800000, 24'h000100, lat, b0);
        tests++;
        if ({quotient, remainder, Z, Neg, V, dz} !== {24'h800000, 24'h0, 4'b0100}) begin
            fails++;
            $display("FAIL exact_min_boundary: got q=%h r=%h ZNVd=%b%b%b%b, expected 800000 000000 0100",
                     quotient, remainder, Z, Neg, V, dz);
        end
    endtask

    task automatic test_div_zero();
        int lat;
        logic b0;
        run_div(24'h000100, 24'h000000, lat, b0);
        tests++;
        if ({quotient, remainder, Z, Neg, V, dz} !== {24'h7FFFFF, 24'h0, 4'b0011}) begin
            fails++;
            $display("FAIL dz_pos: got q=%h r=%h ZNVd=%b%b%b%b, expected 7fffff 000000 0011",
                     quotient, remainder, Z, Neg, V, dz);
        end
        tests++;
        if (lat !== LAT) begin
            fails++;
            $display("FAIL dz_latency: got %0d, expected %0d", lat, LAT);
        end
        run_div(24'hFFFF00, 24'h000000, lat, b0);
        tests++;
        if ({quotient, remainder, Z, Neg, V, dz} !== {24'h800000, 24'h0, 4'b0111}) begin
            fails++;
            $display("FAIL dz_neg: got q=%h r=%h ZNVd=%b%b%b%b, expected 800000 000000 0111",
                     quotient, remainder, Z, Neg, V, dz);
        end
    endtask

    task automatic test_zero();
        int lat;
        logic b0;
        run_div(24'h000000, 24'h000300, lat, b0);
        tests++;
        if ({quotient, remainder, Z, Neg, V, dz} !== {24'h0, 24'h0, 4'b1000}) begin
            fails++;
            $display("FAIL zero_result: got q=%h r=%h ZNVd=%b%b%b%b, expected 000000 000000 1000",
                     quotient, remainder, Z, Neg, V, dz);
        end
    endtask

    // Results hold across a new start.
    // They change only once the next division finishes.
    task automatic test_back_to_back();
        int lat;
        logic b0;
        run_div(24'h000100, 24'h000300, lat, b0);
        @(negedge clk);
        dividend = 24'hFFFFA0;
        divisor  = 24'h000040;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        tests++;
        if ({busy, quotient, remainder} !== {1'b1, 24'h000055, 24'h000100}) begin
            fails++;
            $display("FAIL hold_after_start: got busy=%b q=%h r=%h, expected 1 000055 000100",
                     busy, quotient, remainder);
        end
        lat = 5;
        while (done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        tests++;
        if (lat !== LAT || quotient !== 24'hFFFE80) begin
            fails++;
            $display("FAIL back_to_back: got lat=%0d q=%h, expected %0d fffe80", lat, quotient, LAT);
        end
    endtask

    task automatic test_ignore_start();
        int ndone;
        int first;
        @(negedge clk);
        dividend = 24'h000180;
        divisor  = 24'h000080;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        first = -1;
        for (int k = 0; k < 80; k++) begin
            if (done === 1'b1) begin
                ndone++;
                if (first < 0) first = k;
            end
            start = (k == 5 || k == 33);
            if (start) begin
                dividend = 24'h000100;
                divisor  = 24'h000000;
            end
            @(negedge clk);
        end
        start = 1'b0;
        tests++;
        if (ndone !== 1 || first !== LAT) begin
            fails++;
            $display("FAIL ignore_start_done: got %0d dones first at %0d, expected 1 at %0d", ndone, first, LAT);
        end
        tests++;
        if ({quotient, dz} !== {24'h000300, 1'b0}) begin
            fails++;
            $display("FAIL ignore_start_result: got q=%h dz=%b, expected 000300 0", quotient, dz);
        end
    endtask

    // Reset in the middle of a division.
    // It clears the outputs, and no done pulse follows.
    task automatic test_reset_abort();
        int lat;
        logic b0;
        int ndone;
        run_div(24'h7FFFFF, 24'h000001, lat, b0);
        @(negedge clk);
        dividend = 24'h000180;
        divisor  = 24'h000080;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if ({busy, done, quotient, remainder, Z, Neg, V, dz} !== {2'b00, 24'h0, 24'h0, 4'b1000}) begin
            fails++;
            $display("FAIL reset_abort_values: got busy=%b done=%b q=%h r=%h ZNVd=%b%b%b%b, expected 0 0 000000 000000 1000",
                     busy, done, quotient, remainder, Z, Neg, V, dz);
        end
        ndone = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) ndone++;
        end
        tests++;
        if (ndone !== 0) begin
            fails++;
            $display("FAIL reset_abort_no_done: got %0d busy/done cycles, expected 0", ndone);
        end
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        test_reset();
        test_basic();
        test_signs();
        test_trunc();
        test_overflow();
        test_div_zero();
        test_zero();
        test_back_to_back();
        test_ignore_start();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
